// File: rtl/decode_stage.sv
// decode_stage -- registered RV32I decode between fetch and execute.
//
// Takes a raw instruction and its PC over a valid/ready handshake. It decodes
// the instruction combinationally and captures the result into the output
// register, or into the skid entry when execute is stalled. The result is
// presented as a registered control/operand bundle.
//
// Parameters
//   XLEN  PC / immediate width (32 or 64); immediates are sign-extended.
//   SKID  1: two entries, in_ready is a flop. 0: one entry,
//         in_ready = !out_valid || out_ready.
//
// Ports
//   clock, reset        rising-edge clock, async active-low reset
//   flush               synchronous kill of every buffered entry
//   in_valid/in_ready   fetch handshake; in_instr, in_pc carried with it
//   out_valid/out_ready execute handshake
//   out_pc, rd, rs1, rs2, imm, alu_op, alu_src, a_pc, reg_write, mem_read,
//   mem_write, branch, jal, jalr, mem_size, mem_unsigned, illegal
//                       registered decode bundle

package decode_pkg;

  // ALU operation codes shared with the execute stage.
  typedef enum logic [3:0] {
    ALU_NONE = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10,
    ALU_SEQ  = 4'd11,
    ALU_SNE  = 4'd12,
    ALU_SGE  = 4'd13,
    ALU_SGEU = 4'd14
  } alu_op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit SKID = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      alu_op,
  output logic            alu_src,
  output logic            a_pc,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jal,
  output logic            jalr,
  output logic [1:0]      mem_size,
  output logic            mem_unsigned,
  output logic            illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    alu_op_e         alu_op;
    logic            alu_src;
    logic            a_pc;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jal;
    logic            jalr;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic            illegal;
  } bundle_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        shamt_ok;
  logic        bad;
  logic        writes_rd;
  bundle_t     dec;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};

  // Bit 25 is shamt[5]; only a 64-bit datapath has a use for it.
  assign shamt_ok = (XLEN > 32) || !in_instr[25];

  always_comb begin
    // NOTE: every field gets a default before the case, so no path through
    // the block leaves a signal unassigned and no latch is inferred.
    dec       = '0;
    bad       = 1'b0;
    writes_rd = 1'b0;
    dec.pc    = in_pc;
    dec.rd    = in_instr[11:7];
    dec.rs1   = in_instr[19:15];
    dec.rs2   = in_instr[24:20];

    case (opcode)
      OPC_LUI: begin
        dec.imm     = sext(imm_u);
        dec.alu_op  = ALU_ADD;
        dec.alu_src = 1'b1;
        dec.rs1     = 5'd0;   // execute computes x0 + imm
        writes_rd   = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm     = sext(imm_u);
        dec.alu_op  = ALU_ADD;
        dec.alu_src = 1'b1;
        dec.a_pc    = 1'b1;
        writes_rd   = 1'b1;
      end
      OPC_JAL: begin
        dec.imm   = sext(imm_j);
        dec.jal   = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_JALR: begin
        dec.imm     = sext(imm_i);
        dec.alu_op  = ALU_ADD;
        dec.alu_src = 1'b1;
        dec.jalr    = 1'b1;
        writes_rd   = 1'b1;
        bad         = (funct3 != 3'd0);
      end
      OPC_BRANCH: begin
        dec.imm    = sext(imm_b);
        dec.branch = 1'b1;
        case (funct3)
          3'd0:    dec.alu_op = ALU_SEQ;
          3'd1:    dec.alu_op = ALU_SNE;
          3'd4:    dec.alu_op = ALU_SLT;
          3'd5:    dec.alu_op = ALU_SGE;
          3'd6:    dec.alu_op = ALU_SLTU;
          3'd7:    dec.alu_op = ALU_SGEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.imm          = sext(imm_i);
        dec.alu_op       = ALU_ADD;
        dec.alu_src      = 1'b1;
        dec.mem_read     = 1'b1;
        dec.mem_size     = funct3[1:0];
        dec.mem_unsigned = funct3[2];
        writes_rd        = 1'b1;
        // funct3 3, 6 and 7 have no RV32I load.
        bad = (funct3[1:0] == 2'd3) || (funct3[2] && funct3[1]);
      end
      OPC_STORE: begin
        dec.imm       = sext(imm_s);
        dec.alu_op    = ALU_ADD;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.mem_size  = funct3[1:0];
        bad           = (funct3 > 3'd2);
      end
      OPC_OP_IMM: begin
        dec.imm     = sext(imm_i);
        dec.alu_src = 1'b1;
        writes_rd   = 1'b1;
        case (funct3)
          3'd0: dec.alu_op = ALU_ADD;
          3'd2: dec.alu_op = ALU_SLT;
          3'd3: dec.alu_op = ALU_SLTU;
          3'd4: dec.alu_op = ALU_XOR;
          3'd6: dec.alu_op = ALU_OR;
          3'd7: dec.alu_op = ALU_AND;
          3'd1: begin
            dec.alu_op = ALU_SLL;
            bad        = (in_instr[31:26] != 6'd0) || !shamt_ok;
          end
          default: begin
            // funct3 = 5: bit 30 picks arithmetic over logical shift.
            dec.alu_op = in_instr[30] ? ALU_SRA : ALU_SRL;
            bad        = in_instr[31] || (in_instr[29:26] != 4'd0) || !shamt_ok;
          end
        endcase
      end
      OPC_OP: begin
        writes_rd = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'd0:    dec.alu_op = ALU_ADD;
            3'd1:    dec.alu_op = ALU_SLL;
            3'd2:    dec.alu_op = ALU_SLT;
            3'd3:    dec.alu_op = ALU_SLTU;
            3'd4:    dec.alu_op = ALU_XOR;
            3'd5:    dec.alu_op = ALU_SRL;
            3'd6:    dec.alu_op = ALU_OR;
            default: dec.alu_op = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'd0) begin
          dec.alu_op = ALU_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'd5) begin
          dec.alu_op = ALU_SRA;
        end else begin
          bad = 1'b1;
        end
      end
      // Every valid opcode ends in 2'b11, so compressed encodings land here too.
      default: bad = 1'b1;
    endcase

    dec.reg_write = writes_rd && (dec.rd != 5'd0) && !bad;
    dec.illegal   = bad;
    if (bad) begin
      // Still delivered so execute can trap, but with no side effects.
      dec.alu_op       = ALU_NONE;
      dec.alu_src      = 1'b0;
      dec.a_pc         = 1'b0;
      dec.mem_read     = 1'b0;
      dec.mem_write    = 1'b0;
      dec.branch       = 1'b0;
      dec.jal          = 1'b0;
      dec.jalr         = 1'b0;
      dec.mem_size     = 2'd0;
      dec.mem_unsigned = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output / skid buffer
  // ---------------------------------------------------------------------------
  state_e  state_q, state_d;
  bundle_t out_q, out_d;
  bundle_t skid_q, skid_d;
  logic    out_valid_q, out_valid_d;
  logic    in_ready_q, in_ready_d;
  logic    accept, consume;

  assign in_ready = SKID ? in_ready_q : (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          out_d   = dec;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          out_d = dec;
        end else if (accept) begin
          // Reachable only with SKID = 1: otherwise in_ready is low here.
          state_d = ST_TWO;
          skid_d  = dec;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (consume) begin
          state_d = ST_ONE;
          out_d   = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_TWO);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values that
      // were present before this edge, regardless of statement order.
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // NOTE: skid_q carries no reset. It is read only in ST_TWO, and ST_TWO is
  // entered only on the same edge that writes it.
  always_ff @(posedge clock) begin
    skid_q <= skid_d;
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_q.pc;
  assign rd           = out_q.rd;
  assign rs1          = out_q.rs1;
  assign rs2          = out_q.rs2;
  assign imm          = out_q.imm;
  assign alu_op       = out_q.alu_op;
  assign alu_src      = out_q.alu_src;
  assign a_pc         = out_q.a_pc;
  assign reg_write    = out_q.reg_write;
  assign mem_read     = out_q.mem_read;
  assign mem_write    = out_q.mem_write;
  assign branch       = out_q.branch;
  assign jal          = out_q.jal;
  assign jalr         = out_q.jalr;
  assign mem_size     = out_q.mem_size;
  assign mem_unsigned = out_q.mem_unsigned;
  assign illegal      = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage -- directed checks of decode_stage in two configurations:
//   sel = 0: XLEN = 32, SKID = 1      sel = 1: XLEN = 64, SKID = 0
// The selected instance receives the stimulus. The idle instance is held
// flushed with out_ready high.
module tb_decode_stage;
  import decode_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        sel;
  logic        flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  // Instance A: XLEN = 32, SKID = 1
  logic        a_flush, a_in_valid, a_out_ready, a_in_ready, a_out_valid;
  logic [31:0] a_out_pc, a_imm;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [3:0]  a_alu_op;
  logic        a_alu_src, a_a_pc, a_reg_write, a_mem_read, a_mem_write;
  logic        a_branch, a_jal, a_jalr, a_mem_unsigned, a_illegal;
  logic [1:0]  a_mem_size;

  // Instance B: XLEN = 64, SKID = 0
  logic        b_flush, b_in_valid, b_out_ready, b_in_ready, b_out_valid;
  logic [63:0] b_out_pc, b_imm;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [3:0]  b_alu_op;
  logic        b_alu_src, b_a_pc, b_reg_write, b_mem_read, b_mem_write;
  logic        b_branch, b_jal, b_jalr, b_mem_unsigned, b_illegal;
  logic [1:0]  b_mem_size;

  assign a_in_valid  = in_valid && !sel;
  assign a_flush     = sel ? 1'b1 : flush;
  assign a_out_ready = sel ? 1'b1 : out_ready;
  assign b_in_valid  = in_valid && sel;
  assign b_flush     = sel ? flush : 1'b1;
  assign b_out_ready = sel ? out_ready : 1'b1;

  decode_stage #(.XLEN(32), .SKID(1'b1)) u_dut_a (
    .clock(clock), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
    .in_pc(in_pc[31:0]), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_pc(a_out_pc), .rd(a_rd), .rs1(a_rs1), .rs2(a_rs2), .imm(a_imm),
    .alu_op(a_alu_op), .alu_src(a_alu_src), .a_pc(a_a_pc),
    .reg_write(a_reg_write), .mem_read(a_mem_read), .mem_write(a_mem_write),
    .branch(a_branch), .jal(a_jal), .jalr(a_jalr), .mem_size(a_mem_size),
    .mem_unsigned(a_mem_unsigned), .illegal(a_illegal)
  );

  decode_stage #(.XLEN(64), .SKID(1'b0)) u_dut_b (
    .clock(clock), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_pc(b_out_pc), .rd(b_rd), .rs1(b_rs1), .rs2(b_rs2), .imm(b_imm),
    .alu_op(b_alu_op), .alu_src(b_alu_src), .a_pc(b_a_pc),
    .reg_write(b_reg_write), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .branch(b_branch), .jal(b_jal), .jalr(b_jalr), .mem_size(b_mem_size),
    .mem_unsigned(b_mem_unsigned), .illegal(b_illegal)
  );

  typedef struct packed {
    logic        in_ready;
    logic        out_valid;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic [3:0]  alu_op;
    logic        alu_src, a_pc, reg_write, mem_read, mem_write;
    logic        branch, jal, jalr;
    logic [1:0]  mem_size;
    logic        mem_unsigned, illegal;
  } obs_t;

  typedef struct packed {
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        alu_src, a_pc, reg_write, mem_read, mem_write;
    logic        branch, jal, jalr;
    logic [1:0]  mem_size;
    logic        mem_unsigned, illegal;
  } exp_t;

  obs_t oa, ob, o;
  assign oa = '{a_in_ready, a_out_valid, {32'h0, a_out_pc}, {32'h0, a_imm},
                a_rd, a_rs1, a_rs2, a_alu_op, a_alu_src, a_a_pc, a_reg_write,
                a_mem_read, a_mem_write, a_branch, a_jal, a_jalr, a_mem_size,
                a_mem_unsigned, a_illegal};
  assign ob = '{b_in_ready, b_out_valid, b_out_pc, b_imm,
                b_rd, b_rs1, b_rs2, b_alu_op, b_alu_src, b_a_pc, b_reg_write,
                b_mem_read, b_mem_write, b_branch, b_jal, b_jalr, b_mem_size,
                b_mem_unsigned, b_illegal};
  assign o  = sel ? ob : oa;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cfg %0d): got 0x%0h, expected 0x%0h", tag, sel, got, exp);
    end
  endtask

  task automatic check_bundle(input string name, input exp_t e);
    logic [63:0] imm_x;
    imm_x = sel ? {{32{e.imm[31]}}, e.imm} : {32'h0, e.imm};
    check({name, ".valid"},     64'(o.out_valid),    64'd1);
    check({name, ".rd"},        64'(o.rd),           64'(e.rd));
    check({name, ".rs1"},       64'(o.rs1),          64'(e.rs1));
    check({name, ".rs2"},       64'(o.rs2),          64'(e.rs2));
    check({name, ".alu_op"},    64'(o.alu_op),       64'(e.alu_op));
    check({name, ".alu_src"},   64'(o.alu_src),      64'(e.alu_src));
    check({name, ".a_pc"},      64'(o.a_pc),         64'(e.a_pc));
    check({name, ".reg_write"}, 64'(o.reg_write),    64'(e.reg_write));
    check({name, ".mem_read"},  64'(o.mem_read),     64'(e.mem_read));
    check({name, ".mem_write"}, 64'(o.mem_write),    64'(e.mem_write));
    check({name, ".branch"},    64'(o.branch),       64'(e.branch));
    check({name, ".jal"},       64'(o.jal),          64'(e.jal));
    check({name, ".jalr"},      64'(o.jalr),         64'(e.jalr));
    check({name, ".mem_size"},  64'(o.mem_size),     64'(e.mem_size));
    check({name, ".mem_uns"},   64'(o.mem_unsigned), 64'(e.mem_unsigned));
    check({name, ".illegal"},   64'(o.illegal),      64'(e.illegal));
    if (!e.illegal) check({name, ".imm"}, o.imm, imm_x);
  endtask

  // Offer one instruction with out_ready high; check it on the next cycle.
  task automatic decode_vec(input string name, input logic [31:0] instr,
                            input logic [31:0] pc, input exp_t e);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_pc     = {32'h0, pc};
    out_ready = 1'b1;
    @(negedge clock);
    check_bundle(name, e);
    check({name, ".pc"}, o.pc, {32'h0, pc});
  endtask

  localparam logic [31:0] I_ADDI = 32'hFFF10093;  // addi x1,x2,-1
  localparam logic [31:0] I_LUI  = 32'h123452B7;  // lui  x5,0x12345
  localparam logic [31:0] I_SUB  = 32'h402081B3;  // sub  x3,x1,x2
  localparam logic [31:0] I_AUI  = 32'h00001517;  // auipc x10,1

  task automatic run_config();
    exp_t e;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0; in_pc = 64'h0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("rst.out_valid", 64'(o.out_valid), 64'd0);
    check("rst.in_ready",  64'(o.in_ready),  64'd1);
    check("rst.pc",        o.pc,             64'd0);
    check("rst.imm",       o.imm,            64'd0);
    check("rst.rd",        64'(o.rd),        64'd0);
    check("rst.alu_op",    64'(o.alu_op),    64'(ALU_NONE));
    check("rst.reg_write", 64'(o.reg_write), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    // ---- decode vectors, back to back ----
    decode_vec("addi", I_ADDI, 32'h1000, '{rd:5'd1, rs1:5'd2, rs2:5'd31,
      imm:32'hFFFF_FFFF, alu_op:ALU_ADD, alu_src:1'b1, reg_write:1'b1, default:'0});
    decode_vec("lui", I_LUI, 32'h1004, '{rd:5'd5, rs1:5'd0, rs2:5'd3,
      imm:32'h1234_5000, alu_op:ALU_ADD, alu_src:1'b1, reg_write:1'b1, default:'0});
    decode_vec("sw", 32'h00322423, 32'h1008, '{rd:5'd8, rs1:5'd4, rs2:5'd3,
      imm:32'd8, alu_op:ALU_ADD, alu_src:1'b1, mem_write:1'b1, mem_size:2'd2, default:'0});
    decode_vec("zero", 32'h00000000, 32'h100C, '{illegal:1'b1, default:'0});
    decode_vec("ld_f7", 32'h00007003, 32'h1010, '{illegal:1'b1, default:'0});
    decode_vec("bltu", 32'h0062E863, 32'h1014, '{rd:5'd16, rs1:5'd5, rs2:5'd6,
      imm:32'd16, alu_op:ALU_SLTU, branch:1'b1, default:'0});
    decode_vec("jal", 32'hFF9FF0EF, 32'h1018, '{rd:5'd1, rs1:5'd31, rs2:5'd25,
      imm:32'hFFFF_FFF8, alu_op:ALU_NONE, jal:1'b1, reg_write:1'b1, default:'0});
    decode_vec("auipc", I_AUI, 32'h101C, '{rd:5'd10, rs1:5'd0, rs2:5'd0,
      imm:32'h0000_1000, alu_op:ALU_ADD, alu_src:1'b1, a_pc:1'b1, reg_write:1'b1, default:'0});
    decode_vec("sub", I_SUB, 32'h1020, '{rd:5'd3, rs1:5'd1, rs2:5'd2,
      imm:32'd0, alu_op:ALU_SUB, reg_write:1'b1, default:'0});
    decode_vec("srai", 32'h40325213, 32'h1024, '{rd:5'd4, rs1:5'd4, rs2:5'd3,
      imm:32'h403, alu_op:ALU_SRA, alu_src:1'b1, reg_write:1'b1, default:'0});
    decode_vec("lhu", 32'h00245383, 32'h1028, '{rd:5'd7, rs1:5'd8, rs2:5'd2,
      imm:32'd2, alu_op:ALU_ADD, alu_src:1'b1, mem_read:1'b1, reg_write:1'b1,
      mem_size:2'd1, mem_unsigned:1'b1, default:'0});
    decode_vec("nop_x0", 32'h00000013, 32'h102C, '{imm:32'd0, alu_op:ALU_ADD,
      alu_src:1'b1, default:'0});
    decode_vec("jalr_f3", 32'h000010E7, 32'h1030, '{rd:5'd1, illegal:1'b1, default:'0});
    if (sel) e = '{rd:5'd1, rs1:5'd1, imm:32'd32, alu_op:ALU_SLL, alu_src:1'b1,
                   reg_write:1'b1, default:'0};
    else     e = '{rd:5'd1, rs1:5'd1, illegal:1'b1, default:'0};
    decode_vec("slli_b25", 32'h02009093, 32'h1034, e);
    in_valid = 1'b0;
    @(negedge clock);
    check("drain.out_valid", 64'(o.out_valid), 64'd0);

    // ---- backpressure: three offers with execute stalled ----
    out_ready = 1'b0; in_valid = 1'b1; in_instr = I_ADDI; in_pc = 64'h2000;
    @(negedge clock);
    check("bp1.out_valid", 64'(o.out_valid), 64'd1);
    check("bp1.pc",        o.pc,             64'h2000);
    check("bp1.in_ready",  64'(o.in_ready),  sel ? 64'd0 : 64'd1);
    in_instr = I_LUI; in_pc = 64'h2004;
    @(negedge clock);
    check("bp2.in_ready", 64'(o.in_ready), 64'd0);
    check("bp2.pc",       o.pc,            64'h2000);
    check("bp2.rd",       64'(o.rd),       64'd1);
    if (!sel) begin
      in_instr = I_SUB; in_pc = 64'h2008;
    end
    @(negedge clock);
    check("bp3.in_ready", 64'(o.in_ready), 64'd0);
    check("bp3.pc",       o.pc,            64'h2000);
    out_ready = 1'b1;
    #1;
    check("bp3.in_ready_rise", 64'(o.in_ready), sel ? 64'd1 : 64'd0);
    @(negedge clock);
    check("bp4.pc",       o.pc,            64'h2004);
    check("bp4.rd",       64'(o.rd),       64'd5);
    check("bp4.in_ready", 64'(o.in_ready), 64'd1);
    if (sel) begin
      in_instr = I_SUB; in_pc = 64'h2008;
    end
    @(negedge clock);
    check("bp5.pc",        o.pc,             64'h2008);
    check("bp5.rd",        64'(o.rd),        64'd3);
    check("bp5.out_valid", 64'(o.out_valid), 64'd1);
    in_valid = 1'b0;
    @(negedge clock);
    check("bp6.out_valid", 64'(o.out_valid), 64'd0);

    // ---- flush while full, with a same-cycle offer ----
    out_ready = 1'b0; in_valid = 1'b1; in_instr = I_ADDI; in_pc = 64'h3000;
    @(negedge clock);
    in_instr = I_LUI; in_pc = 64'h3004;
    @(negedge clock);
    check("fl.pre_in_ready", 64'(o.in_ready), 64'd0);
    flush = 1'b1; out_ready = 1'b1; in_instr = I_SUB; in_pc = 64'h3008;
    @(negedge clock);
    check("fl.out_valid", 64'(o.out_valid), 64'd0);
    check("fl.in_ready",  64'(o.in_ready),  64'd1);
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    check("fl.no_ghost", 64'(o.out_valid), 64'd0);
    in_valid = 1'b1; in_instr = I_AUI; in_pc = 64'h300C;
    @(negedge clock);
    check("fl.next_valid", 64'(o.out_valid), 64'd1);
    check("fl.next_pc",    o.pc,             64'h300C);
    check("fl.next_rd",    64'(o.rd),        64'd10);
    in_valid = 1'b0;
    @(negedge clock);

    // ---- asynchronous reset while holding one entry ----
    out_ready = 1'b0; in_valid = 1'b1; in_instr = I_ADDI; in_pc = 64'h4000;
    @(negedge clock);
    check("ar.pre_valid", 64'(o.out_valid), 64'd1);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("ar.out_valid", 64'(o.out_valid), 64'd0);
    check("ar.in_ready",  64'(o.in_ready),  64'd1);
    check("ar.pc",        o.pc,             64'd0);
    check("ar.rd",        64'(o.rd),        64'd0);
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b1; in_instr = I_LUI; in_pc = 64'h4004;
    @(negedge clock);
    check("ar.first_valid",    64'(o.out_valid), 64'd1);
    check("ar.first_pc",       o.pc,             64'h4004);
    check("ar.first_rd",       64'(o.rd),        64'd5);
    check("ar.first_in_ready", 64'(o.in_ready),  sel ? 64'd0 : 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    check("ar.drain", 64'(o.out_valid), 64'd0);
  endtask

  initial begin
    sel = 1'b0;
    run_config();
    sel = 1'b1;
    run_config();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
